// File: rtl/vec_mul_if.sv
// Handshake/data bundle for the vec_mul dot-product unit.
// The master drives the enable qualifier and the packed x/k vectors.
// The slave (vec_mul) returns the signed sum y and its v_valid flag.
interface vec_mul_if #(
    parameter int C   = 9,
    parameter int W_X = 8,
    parameter int W_K = 8
);
    localparam int W_Y = W_X + W_K + $clog2(C);

    logic                        enable;
    logic [C-1:0][W_X-1:0]       x;
    logic [C-1:0][W_K-1:0]       k;
    logic signed [W_Y-1:0]       y;
    logic                        v_valid;

    modport master (
        output enable, x, k,
        input  y, v_valid
    );

    modport slave (
        input  enable, x, k,
        output y, v_valid
    );
endinterface

// File: rtl/vec_mul.sv
// vec_mul: pipelined signed dot product sum(x[c]*k[c]) over C element pairs.
// Stage 0 registers the C full-width products; each following stage is one
// level of a registered binary adder tree, so LATENCY = $clog2(C)+1.
// enable advances every data and valid register together; enable=0 stalls.
// Optional feature macro VEC_MUL_RELU_EN: when defined the final stage
// registers max(sum,0); when undefined y is the raw signed sum.
module vec_mul #(
    parameter int C   = 9,
    parameter int W_X = 8,
    parameter int W_K = 8
) (
    input logic     clk,
    input logic     rstn,
    vec_mul_if.slave bus
);
    localparam int W_P     = W_X + W_K;
    localparam int LEVELS  = $clog2(C);
    localparam int W_Y     = W_P + LEVELS;
    localparam int LATENCY = LEVELS + 1;

    // Every tree node is carried at the full result width. Sign-extending all
    // operands up front is arithmetically identical to growing one bit per
    // level, and the result width already bounds the largest possible sum.
    typedef logic signed [W_Y-1:0] acc_t;

    // Index [level][node]. One spare node column (index C) is always zero so
    // an unpaired node at an odd-sized level adds zero, i.e. passes unchanged.
    acc_t             sum_d [LEVELS+1][C+1];
    acc_t             sum_p [LEVELS+1][C+1];
    logic [LATENCY-1:0] vld_p;

    // Exact signed product, sign-extended to the accumulator width.
    function automatic acc_t mul_ext(input logic signed [W_X-1:0] a,
                                     input logic signed [W_K-1:0] b);
        logic signed [W_P-1:0] p;
        p = a * b;
        return acc_t'(p);
    endfunction

    // Final-stage activation applied before the output register.
    function automatic acc_t relu(input acc_t s);
`ifdef VEC_MUL_RELU_EN
        return s[W_Y-1] ? acc_t'(0) : s;
`else
        return s;
`endif
    endfunction

    // Next-state values for every pipeline level: products, then adder tree.
    always_comb begin
        int n;
        sum_d = '{default: '0};
        n     = C;
        for (int c = 0; c < C; c++) begin
            sum_d[0][c] = mul_ext(bus.x[c], bus.k[c]);
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int i = 0; i < (C + 1) / 2; i++) begin
                if (i < (n + 1) / 2) begin
                    sum_d[l][i] = sum_p[l-1][2*i] + sum_p[l-1][2*i+1];
                end
            end
            n = (n + 1) / 2;
        end
        sum_d[LEVELS][0] = relu(sum_d[LEVELS][0]);
    end

    // Pipeline registers: cleared asynchronously, advance only when enabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_p <= '{default: '0};
            vld_p <= '0;
        end else if (bus.enable) begin
            sum_p <= sum_d;
            vld_p <= LATENCY'({vld_p, 1'b1});
        end
    end

    assign bus.y       = sum_p[LEVELS][0];
    assign bus.v_valid = vld_p[LATENCY-1];
endmodule

// File: tb/tb_vec_mul.sv
// Directed bench for vec_mul (C=9, W_X=W_K=8, W_Y=20, LATENCY=5).
module tb_vec_mul;
    localparam int C   = 9;
    localparam int W_X = 8;
    localparam int W_K = 8;
    localparam int W_Y = 20;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    logic signed [W_X-1:0] xa [C];
    logic signed [W_K-1:0] ka [C];
    logic signed [W_Y-1:0] exp_q [10];
    logic signed [W_Y-1:0] exp_a;
    logic signed [W_Y-1:0] exp_b;

    always #5 clk = ~clk;

    vec_mul_if #(.C(C), .W_X(W_X), .W_K(W_K)) bus ();

    vec_mul #(.C(C), .W_X(W_X), .W_K(W_K)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic signed [W_Y-1:0] obs,
                         input logic signed [W_Y-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int relu_m(input int s);
`ifdef VEC_MUL_RELU_EN
        return (s < 0) ? 0 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic signed [W_Y-1:0] model();
        int s;
        s = 0;
        for (int c = 0; c < C; c++) s += int'(xa[c]) * int'(ka[c]);
        return W_Y'(relu_m(s));
    endfunction

    task automatic fill(input int xv, input int kv);
        for (int c = 0; c < C; c++) begin
            xa[c] = W_X'(xv);
            ka[c] = W_K'(kv);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < C; c++) begin
            bus.x[c] = xa[c];
            bus.k[c] = ka[c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstn       = 1'b1;
        bus.enable = 1'b0;
        fill(0, 0);
        drive();

        // Asynchronous reset with no clock edge
        #1 rstn = 1'b0;
        #1;
        check("reset_y", bus.y, 0);
        check("reset_v", W_Y'(bus.v_valid), 0);

        // All ones: result 9 after 5 enabled edges, invalid before that
        @(negedge clk);
        rstn       = 1'b1;
        bus.enable = 1'b1;
        fill(1, 1);
        drive();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("ones_v_early", W_Y'(bus.v_valid), 0);
        end
        tick();
        check("ones_y", bus.y, 9);
        check("ones_v", W_Y'(bus.v_valid), 1);

        // Extremes: -128*-128 and -128*127
        fill(-128, -128);
        drive();
        for (int i = 0; i < 4; i++) tick();
        check("latency_hold", bus.y, 9);
        tick();
        check("max_pos", bus.y, 147456);
        fill(-128, 127);
        drive();
        for (int i = 0; i < 5; i++) tick();
`ifdef VEC_MUL_RELU_EN
        check("max_neg", bus.y, 0);
`else
        check("max_neg", bus.y, -146304);
`endif

        // Back-to-back stream of pseudo-random vectors, no bubbles
        for (int n = 0; n < 14; n++) begin
            if (n < 10) begin
                for (int c = 0; c < C; c++) begin
                    xa[c] = W_X'($urandom);
                    ka[c] = W_K'($urandom);
                end
                exp_q[n] = model();
            end else begin
                fill(2, 3);
            end
            drive();
            tick();
            if (n >= 4) begin
                check($sformatf("stream_y%0d", n - 4), bus.y, exp_q[n-4]);
                check($sformatf("stream_v%0d", n - 4), W_Y'(bus.v_valid), 1);
            end
        end
        tick();
        check("fill_z", bus.y, 54);

        // Stall for two cycles with A and B in flight
        fill(5, 7);
        exp_a = model();
        drive();
        tick();
        fill(-3, 100);
        exp_b = model();
        drive();
        tick();
        bus.enable = 1'b0;
        fill(1, 1);
        drive();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_y", bus.y, 54);
            check("stall_v", W_Y'(bus.v_valid), 1);
        end
        bus.enable = 1'b1;
        fill(2, 3);
        drive();
        tick();
        check("resume_z1", bus.y, 54);
        tick();
        check("resume_z2", bus.y, 54);
        tick();
        check("resume_a", bus.y, exp_a);
        tick();
        check("resume_b", bus.y, exp_b);
        check("resume_v", W_Y'(bus.v_valid), 1);

        // Reset pulse mid-flight discards in-flight data
        fill(10, 10);
        drive();
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        check("midrst_y", bus.y, 0);
        check("midrst_v", W_Y'(bus.v_valid), 0);
        fill(4, 6);
        drive();
        #1 rstn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("post_rst_y", bus.y, 0);
            check("post_rst_v", W_Y'(bus.v_valid), 0);
        end
        tick();
        check("post_rst_res", bus.y, 216);
        check("post_rst_vld", W_Y'(bus.v_valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
